// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/memory/writeback.
// Optional feature: define MC_CTRL_BNE_EN to run opcode 0x05 (bne) through the branch state.
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         opcode_i,
    input  logic               mem_ready_i,
    input  logic               zero_i,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic [1:0]         pc_source_o,
    output logic               iord_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               ir_write_o,
    output logic               mem_to_reg_o,
    output logic               reg_dst_o,
    output logic               reg_write_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [2:0]         alu_op_o,
    output logic               instr_done_o,
    output logic               illegal_o,
    output logic [STATE_W-1:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXE   = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic       illegal_op;

    logic       mem_read_q, mem_read_d;
    logic       mem_write_q, mem_write_d;
    logic       iord_q, iord_d;
    logic       mem_to_reg_q, mem_to_reg_d;
    logic       reg_dst_q, reg_dst_d;
    logic       reg_write_q, reg_write_d;
    logic       alu_src_a_q, alu_src_a_d;
    logic [1:0] alu_src_b_q, alu_src_b_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic [1:0] pc_source_q, pc_source_d;
    logic       done_q, done_d;
    logic       branch_on_ne;

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                opcode_d = opcode_i;
                case (opcode_i)
                    OP_RTYPE:       state_d = S_RTEXE;
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_BEQ:         state_d = S_BEQ;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:         state_d = S_BEQ;
`endif
                    OP_J:           state_d = S_JUMP;
                    OP_ADDI, OP_SLTI: state_d = S_IEXE;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (mem_ready_i) state_d = S_FETCH;
            end
            S_RTEXE:  state_d = S_RTWB;
            S_IEXE:   state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        iord_d       = 1'b0;
        mem_to_reg_d = 1'b0;
        reg_dst_d    = 1'b0;
        reg_write_d  = 1'b0;
        alu_src_a_d  = 1'b0;
        alu_src_b_d  = 2'b00;
        alu_op_d     = 3'b000;
        pc_source_d  = 2'b00;
        done_d       = 1'b0;
        case (state_d)
            S_FETCH: begin
                mem_read_d  = 1'b1;
                alu_src_b_d = 2'b01;
            end
            S_DECODE: alu_src_b_d = 2'b11;
            S_MEMADR: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            S_MEMRD: begin
                mem_read_d = 1'b1;
                iord_d     = 1'b1;
            end
            S_MEMWB: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
                done_d       = 1'b1;
            end
            S_MEMWR: begin
                mem_write_d = 1'b1;
                iord_d      = 1'b1;
            end
            S_RTEXE: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 3'b010;
            end
            S_RTWB: begin
                reg_write_d = 1'b1;
                reg_dst_d   = 1'b1;
                done_d      = 1'b1;
            end
            S_IEXE: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
                alu_op_d    = (opcode_d == OP_SLTI) ? 3'b111 : 3'b011;
            end
            S_IWB: begin
                reg_write_d = 1'b1;
                done_d      = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 3'b001;
                pc_source_d = 2'b01;
                done_d      = 1'b1;
            end
            S_JUMP: begin
                pc_source_d = 2'b10;
                done_d      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_FETCH;
            opcode_q     <= 6'h00;
            mem_read_q   <= 1'b1;
            mem_write_q  <= 1'b0;
            iord_q       <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_dst_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_src_a_q  <= 1'b0;
            alu_src_b_q  <= 2'b01;
            alu_op_q     <= 3'b000;
            pc_source_q  <= 2'b00;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            iord_q       <= iord_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_dst_q    <= reg_dst_d;
            reg_write_q  <= reg_write_d;
            alu_src_a_q  <= alu_src_a_d;
            alu_src_b_q  <= alu_src_b_d;
            alu_op_q     <= alu_op_d;
            pc_source_q  <= pc_source_d;
            done_q       <= done_d;
        end
    end

`ifdef MC_CTRL_BNE_EN
    assign branch_on_ne = (opcode_q == OP_BNE);
`else
    logic unused_zero;
    assign unused_zero  = zero_i;
    assign branch_on_ne = 1'b0;
`endif

    // Handshake-dependent strobes stay combinational so they respond in the ready cycle itself.
    assign pc_write_o      = (state_q == S_JUMP) | ((state_q == S_FETCH) & mem_ready_i);
    assign ir_write_o      = (state_q == S_FETCH) & mem_ready_i;
    assign instr_done_o    = done_q | ((state_q == S_MEMWR) & mem_ready_i);
    assign pc_write_cond_o = (state_q == S_BEQ) & (branch_on_ne ? ~zero_i : 1'b1);
    assign illegal_o       = illegal_op;

    assign pc_source_o  = pc_source_q;
    assign iord_o       = iord_q;
    assign mem_read_o   = mem_read_q;
    assign mem_write_o  = mem_write_q;
    assign mem_to_reg_o = mem_to_reg_q;
    assign reg_dst_o    = reg_dst_q;
    assign reg_write_o  = reg_write_q;
    assign alu_src_a_o  = alu_src_a_q;
    assign alu_src_b_o  = alu_src_b_q;
    assign alu_op_o     = alu_op_q;
    assign state_o      = STATE_W'(state_q);

endmodule
